// File: rtl/mem_responder.sv
// Wait-state memory responder: 2^ADDR_BITS x 16 RAM plus a memory-mapped
// switch input / hex display register at address 16'hFFFF.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    input  logic [15:0] Switches,
    output logic [15:0] RDATA,
    output logic        R,
    output logic        BUSY,
    output logic [15:0] HEX_OUT
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = 1 << ADDR_BITS;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [15:0]         lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_we;
    logic [DATA_W-1:0]   sw_meta;
    logic [DATA_W-1:0]   sw_sync;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                start_c;
    logic                enter_ack_c;
    logic [15:0]         acc_addr_c;
    logic [DATA_W-1:0]   acc_wdata_c;
    logic                acc_we_c;
    logic                acc_io_c;
    logic [ADDR_BITS-1:0] acc_idx_c;

    // Access that completes on this edge; with zero wait states the
    // request is sampled and committed on the same edge.
    always_comb begin
        start_c     = (state == ST_IDLE) && MEM_REQ;
        enter_ack_c = (start_c && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && MEM_REQ && (wait_cnt == CNT_W'(1)));
        acc_addr_c  = start_c ? ADDR   : lat_addr;
        acc_wdata_c = start_c ? WDATA  : lat_wdata;
        acc_we_c    = start_c ? MEM_WE : lat_we;
        acc_io_c    = (acc_addr_c == IO_ADDR);
        acc_idx_c   = acc_addr_c[ADDR_BITS-1:0];
    end

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= Switches;
            sw_sync <= sw_meta;
        end
    end

    // Memory array is intentionally left unreset
    always_ff @(posedge Clk) begin
        if (Reset_al && enter_ack_c && acc_we_c && !acc_io_c)
            mem[acc_idx_c] <= acc_wdata_c;
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            R         <= 1'b0;
            BUSY      <= 1'b0;
            RDATA     <= '0;
            HEX_OUT   <= '0;
        end else begin
            R <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (MEM_REQ) begin
                        lat_addr  <= ADDR;
                        lat_wdata <= WDATA;
                        lat_we    <= MEM_WE;
                        wait_cnt  <= CNT_W'(WAIT_CYCLES);
                        BUSY      <= 1'b1;
                        R         <= (WAIT_CYCLES == 0);
                        state     <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!MEM_REQ) begin
                        wait_cnt <= '0;
                        BUSY     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(1)) begin
                        wait_cnt <= '0;
                        R        <= 1'b1;
                        state    <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!MEM_REQ) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            // Commit writes and capture read data on the ACK-entry edge
            if (enter_ack_c) begin
                if (acc_we_c) begin
                    if (acc_io_c)
                        HEX_OUT <= acc_wdata_c;
                end else begin
                    RDATA <= acc_io_c ? sw_sync : mem[acc_idx_c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected read data is queued when a
// read is issued and compared when the R pulse arrives.
module tb_mem_responder;

    localparam int unsigned AB = 8;
    localparam int unsigned WC = 2;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] Switches;
    logic [15:0] RDATA;
    logic        R;
    logic        BUSY;
    logic [15:0] HEX_OUT;

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .MEM_REQ  (MEM_REQ),
        .MEM_WE   (MEM_WE),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .Switches (Switches),
        .RDATA    (RDATA),
        .R        (R),
        .BUSY     (BUSY),
        .HEX_OUT  (HEX_OUT)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] sb_q [$];
    logic [15:0] mdl [int];
    logic [15:0] exp_hex   = 16'h0000;
    logic [15:0] exp_rdata = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_read(input logic [15:0] a);
        logic [7:0] idx;
        idx = a[7:0];
        if (a == 16'hFFFF) return Switches;
        if (mdl.exists(int'(idx))) return mdl[int'(idx)];
        return 16'h0000;
    endfunction

    // One complete access; hold_extra keeps MEM_REQ high in HOLD that many cycles
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input int hold_extra);
        int          cyc;
        int          pulses;
        logic [15:0] exp_rd;
        logic [7:0]  idx;
        @(negedge Clk);
        MEM_REQ = 1'b1; MEM_WE = we; ADDR = a; WDATA = d;
        if (!we) sb_q.push_back(mdl_read(a));
        @(posedge Clk);
        #1;
        // Scramble inputs after the sampling edge; in-flight access must ignore them
        MEM_WE = ~we; ADDR = ~a; WDATA = ~d;
        chk("busy_start", 32'(BUSY), 32'd1);
        cyc = 1;
        while (!R && cyc < int'(WC) + 6) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(WC + 1));
        if (!we) begin
            exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            if (R) begin
                chk("rdata", 32'(RDATA), 32'(exp_rd));
                exp_rdata = exp_rd;
            end
        end else begin
            idx = a[7:0];
            if (a == 16'hFFFF) exp_hex = d;
            else mdl[int'(idx)] = d;
        end
        @(posedge Clk); #1;
        chk("hex_out", 32'(HEX_OUT), 32'(exp_hex));
        pulses = int'(R);
        chk("busy_hold", 32'(BUSY), 32'd1);
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge Clk); #1;
            pulses += int'(R);
        end
        chk("r_single", 32'(pulses), 32'd0);
        if (hold_extra > 0) chk("busy_long_hold", 32'(BUSY), 32'd1);
        @(negedge Clk);
        MEM_REQ = 1'b0;
        @(posedge Clk); #1;
        chk("busy_idle", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int          pulses;
        logic [15:0] ra;
        logic [15:0] rd;
        Reset_al = 1'b0; MEM_REQ = 1'b0; MEM_WE = 1'b0;
        ADDR = '0; WDATA = '0; Switches = 16'h0000;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        chk("rst_hex", 32'(HEX_OUT), 32'd0);
        @(negedge Clk);
        Reset_al = 1'b1;

        // Basic write then read back
        access(1'b1, 16'h0012, 16'hBEEF, 0);
        access(1'b0, 16'h0012, 16'h0000, 0);

        // I/O write must not touch the aliased memory word 0xFF
        access(1'b1, 16'h00FF, 16'h7777, 0);
        access(1'b1, 16'hFFFF, 16'h1234, 0);
        access(1'b0, 16'h00FF, 16'h0000, 0);

        // Switch read through the synchronizer
        @(negedge Clk);
        Switches = 16'h00A5;
        repeat (3) @(posedge Clk);
        access(1'b0, 16'hFFFF, 16'h0000, 0);

        // Long-held request yields a single acknowledge
        access(1'b0, 16'h0012, 16'h0000, 8);

        // Upper address bits alias onto the low word
        access(1'b1, 16'h0100, 16'h5555, 0);
        access(1'b0, 16'h0000, 16'h0000, 0);

        // Abort in WAIT: no write, no R, RDATA unchanged
        access(1'b1, 16'h0020, 16'h2222, 0);
        @(negedge Clk);
        MEM_REQ = 1'b1; MEM_WE = 1'b1; ADDR = 16'h0020; WDATA = 16'h1111;
        @(posedge Clk);
        @(negedge Clk);
        MEM_REQ = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            pulses += int'(R);
        end
        chk("abort_r", 32'(pulses), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_rdata", 32'(RDATA), 32'(exp_rdata));
        access(1'b0, 16'h0020, 16'h0000, 0);

        // Reset during WAIT cancels the write
        access(1'b1, 16'h0003, 16'hABCD, 0);
        @(negedge Clk);
        MEM_REQ = 1'b1; MEM_WE = 1'b1; ADDR = 16'h0003; WDATA = 16'hFFFF;
        @(posedge Clk);
        @(negedge Clk);
        Reset_al = 1'b0;
        #1;
        chk("rstw_busy", 32'(BUSY), 32'd0);
        exp_hex = 16'h0000;
        exp_rdata = 16'h0000;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            pulses += int'(R);
        end
        @(negedge Clk);
        MEM_REQ = 1'b0;
        Reset_al = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            pulses += int'(R);
        end
        chk("rstw_r", 32'(pulses), 32'd0);
        chk("rstw_idle", 32'(BUSY), 32'd0);
        access(1'b0, 16'h0003, 16'h0000, 0);

        // Random back-to-back traffic over a small address window
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 3)) << 8);
            rd = 16'($urandom);
            access(1'($urandom_range(0, 1)), ra, rd, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
